// File: rtl/csi2_pkt_ctrl.sv
// CSI-2 packet sequencer behind the header Hamming decoder: header parse, payload
// byte accounting, truncation abort and saturating error counters.
module csi2_pkt_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [31:0]      data_i,
    input  logic             error_i,
    input  logic             error_corrected_i,
    output logic             pkt_done_o,
    output logic             hdr_valid_o,
    output logic [1:0]       hdr_vc_o,
    output logic [5:0]       hdr_dt_o,
    output logic [15:0]      hdr_wc_o,
    output logic             pay_valid_o,
    output logic [31:0]      pay_data_o,
    output logic [3:0]       pay_keep_o,
    output logic             pay_last_o,
    output logic [CNT_W-1:0] ecc_corr_cnt_o,
    output logic [CNT_W-1:0] ecc_fail_cnt_o,
    output logic [CNT_W-1:0] trunc_cnt_o,
    input  logic             cnt_clr_i
);

    localparam int unsigned IDLE_W  = 8;
    localparam int unsigned WC_W    = 16;
    localparam int unsigned TOT_W   = 17;
    localparam logic [5:0]  DT_SHORT_MAX = 6'h0F;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        DROP
    } state_t;

    state_t              state_q, state_d;
    logic [WC_W-1:0]     pay_rem_q, pay_rem_d;
    logic [TOT_W-1:0]    tot_rem_q, tot_rem_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;

    logic                done_d, hdr_valid_d, pay_valid_d, pay_last_d;
    logic [1:0]          vc_d;
    logic [5:0]          dt_d;
    logic [15:0]         wc_d;
    logic [31:0]         pay_data_d;
    logic [3:0]          pay_keep_d;
    logic                inc_corr, inc_fail, inc_trunc;
    logic [2:0]          take;

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        pay_rem_d   = pay_rem_q;
        tot_rem_d   = tot_rem_q;
        idle_d      = idle_q;
        done_d      = 1'b0;
        hdr_valid_d = 1'b0;
        vc_d        = hdr_vc_o;
        dt_d        = hdr_dt_o;
        wc_d        = hdr_wc_o;
        pay_valid_d = 1'b0;
        pay_data_d  = pay_data_o;
        pay_keep_d  = 4'h0;
        pay_last_d  = 1'b0;
        inc_corr    = 1'b0;
        inc_fail    = 1'b0;
        inc_trunc   = 1'b0;
        take        = (pay_rem_q >= WC_W'(4)) ? 3'd4 : pay_rem_q[2:0];

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (error_i && !error_corrected_i) begin
                        inc_fail = 1'b1;
                        state_d  = DROP;
                    end else begin
                        hdr_valid_d = 1'b1;
                        vc_d        = data_i[7:6];
                        dt_d        = data_i[5:0];
                        wc_d        = data_i[23:8];
                        inc_corr    = error_i;
                        if (data_i[5:0] <= DT_SHORT_MAX) begin
                            done_d = 1'b1;
                        end else begin
                            pay_rem_d = data_i[23:8];
                            tot_rem_d = TOT_W'(data_i[23:8]) + TOT_W'(2);
                            idle_d    = '0;
                            state_d   = PAYLOAD;
                        end
                    end
                end
            end

            PAYLOAD: begin
                if (valid_i) begin
                    idle_d = '0;
                    // Words after the payload bytes run out carry only CRC
                    if (pay_rem_q != '0) begin
                        pay_valid_d = 1'b1;
                        pay_data_d  = data_i;
                        pay_last_d  = (pay_rem_q <= WC_W'(4));
                        pay_rem_d   = pay_rem_q - WC_W'(take);
                        case (take)
                            3'd1:    pay_keep_d = 4'h1;
                            3'd2:    pay_keep_d = 4'h3;
                            3'd3:    pay_keep_d = 4'h7;
                            default: pay_keep_d = 4'hF;
                        endcase
                    end
                    tot_rem_d = tot_rem_q - TOT_W'(4);
                    if (tot_rem_q <= TOT_W'(4)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                    if (idle_q + IDLE_W'(1) == IDLE_W'(TIMEOUT)) begin
                        done_d    = 1'b1;
                        inc_trunc = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end

            DROP: begin
                if (!valid_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            pay_rem_q      <= '0;
            tot_rem_q      <= '0;
            idle_q         <= '0;
            pkt_done_o     <= 1'b0;
            hdr_valid_o    <= 1'b0;
            hdr_vc_o       <= '0;
            hdr_dt_o       <= '0;
            hdr_wc_o       <= '0;
            pay_valid_o    <= 1'b0;
            pay_data_o     <= '0;
            pay_keep_o     <= '0;
            pay_last_o     <= 1'b0;
            ecc_corr_cnt_o <= '0;
            ecc_fail_cnt_o <= '0;
            trunc_cnt_o    <= '0;
        end else begin
            state_q     <= state_d;
            pay_rem_q   <= pay_rem_d;
            tot_rem_q   <= tot_rem_d;
            idle_q      <= idle_d;
            pkt_done_o  <= done_d;
            hdr_valid_o <= hdr_valid_d;
            hdr_vc_o    <= vc_d;
            hdr_dt_o    <= dt_d;
            hdr_wc_o    <= wc_d;
            pay_valid_o <= pay_valid_d;
            pay_data_o  <= pay_data_d;
            pay_keep_o  <= pay_keep_d;
            pay_last_o  <= pay_last_d;

            // Clear wins over a same-cycle increment; counts stick at all-ones
            if (cnt_clr_i) begin
                ecc_corr_cnt_o <= '0;
                ecc_fail_cnt_o <= '0;
                trunc_cnt_o    <= '0;
            end else begin
                if (inc_corr && (ecc_corr_cnt_o != '1))
                    ecc_corr_cnt_o <= ecc_corr_cnt_o + CNT_W'(1);
                if (inc_fail && (ecc_fail_cnt_o != '1))
                    ecc_fail_cnt_o <= ecc_fail_cnt_o + CNT_W'(1);
                if (inc_trunc && (trunc_cnt_o != '1))
                    trunc_cnt_o <= trunc_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_csi2_pkt_ctrl.sv
// Bench for csi2_pkt_ctrl: packet-level reference model produces a per-cycle
// expectation queue that a single negedge process compares against the DUT.
module tb_csi2_pkt_ctrl;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 4;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             valid_i = 1'b0;
    logic [31:0]      data_i = '0;
    logic             error_i = 1'b0;
    logic             error_corrected_i = 1'b0;
    logic             cnt_clr_i = 1'b0;
    logic             pkt_done_o, hdr_valid_o, pay_valid_o, pay_last_o;
    logic [1:0]       hdr_vc_o;
    logic [5:0]       hdr_dt_o;
    logic [15:0]      hdr_wc_o;
    logic [31:0]      pay_data_o;
    logic [3:0]       pay_keep_o;
    logic [CNT_W-1:0] ecc_corr_cnt_o, ecc_fail_cnt_o, trunc_cnt_o;

    csi2_pkt_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i),
        .error_i(error_i), .error_corrected_i(error_corrected_i),
        .pkt_done_o(pkt_done_o), .hdr_valid_o(hdr_valid_o), .hdr_vc_o(hdr_vc_o),
        .hdr_dt_o(hdr_dt_o), .hdr_wc_o(hdr_wc_o), .pay_valid_o(pay_valid_o),
        .pay_data_o(pay_data_o), .pay_keep_o(pay_keep_o), .pay_last_o(pay_last_o),
        .ecc_corr_cnt_o(ecc_corr_cnt_o), .ecc_fail_cnt_o(ecc_fail_cnt_o),
        .trunc_cnt_o(trunc_cnt_o), .cnt_clr_i(cnt_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic             done, hv, pv, last;
        logic [1:0]       vc;
        logic [5:0]       dt;
        logic [15:0]      wc;
        logic [31:0]      pd;
        logic [3:0]       keep;
        logic [CNT_W-1:0] corr, fail, trunc;
    } exp_t;

    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               last_done_cyc = 0;
    int               last_pv_cyc = 0;
    logic [CNT_W-1:0] m_corr = '0, m_fail = '0, m_trunc = '0;
    bit               rand_clr = 1'b0;
    bit               force_clr = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%h expected=%h", name, cyc, act, exp);
        end
    endfunction

    function automatic exp_t blank();
        exp_t x;
        x.done = 0; x.hv = 0; x.pv = 0; x.last = 0;
        x.vc = '0; x.dt = '0; x.wc = '0; x.pd = '0; x.keep = '0;
        x.corr = '0; x.fail = '0; x.trunc = '0;
        return x;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] c, logic inc);
        return (inc && c != '1) ? c + CNT_W'(1) : c;
    endfunction

    // One input cycle plus the outputs it must produce one clock later
    task automatic step(logic v, logic [31:0] d, logic e, logic ec, logic rst,
                        exp_t x, logic ic, logic ifl, logic it);
        logic clr;
        clr = force_clr | (rand_clr && ($urandom_range(0, 39) == 0));
        valid_i = v; data_i = d; error_i = e; error_corrected_i = ec;
        cnt_clr_i = clr; rst_i = rst;
        if (rst || clr) begin
            m_corr = '0; m_fail = '0; m_trunc = '0;
        end else begin
            m_corr  = sat_inc(m_corr, ic);
            m_fail  = sat_inc(m_fail, ifl);
            m_trunc = sat_inc(m_trunc, it);
        end
        x.corr = m_corr; x.fail = m_fail; x.trunc = m_trunc;
        @(posedge clk_i);
        exp_q.push_back(x);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            step(1'b0, $urandom, 1'($urandom), 1'($urandom), 1'b0, blank(), 0, 0, 0);
    endtask

    // Packet-level model: whole packet's expected output sequence from WC/DT rules
    task automatic send_pkt(logic [1:0] vc, logic [5:0] dt, logic [15:0] wc,
                            logic e, logic ec, int nwords, int max_gap);
        exp_t x;
        logic [31:0] hdr, w;
        int needed, rem;
        hdr = {8'($urandom), wc, vc, dt};
        x = blank();
        if (e && !ec) begin
            step(1'b1, hdr, e, ec, 1'b0, x, 0, 1, 0);
            for (int i = 0; i < nwords; i++)
                step(1'b1, $urandom, 1'($urandom), 1'($urandom), 1'b0, blank(), 0, 0, 0);
            x.done = 1;
            step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, x, 0, 0, 0);
            return;
        end
        x.hv = 1; x.vc = vc; x.dt = dt; x.wc = wc;
        x.done = (dt <= 6'h0F);
        step(1'b1, hdr, e, ec, 1'b0, x, e, 0, 0);
        if (dt <= 6'h0F) return;
        needed = (int'(wc) + 5) / 4;
        for (int i = 0; i < needed && i < nwords; i++) begin
            if (max_gap > 0 && $urandom_range(0, 3) == 0)
                idle($urandom_range(1, max_gap));
            w = $urandom;
            rem = int'(wc) - 4 * i;
            x = blank();
            if (rem > 0) begin
                x.pv = 1; x.pd = w;
                x.keep = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
                x.last = (rem <= 4);
            end
            x.done = (i == needed - 1);
            step(1'b1, w, 1'($urandom), 1'($urandom), 1'b0, x, 0, 0, 0);
        end
        if (nwords < needed) begin
            idle(TIMEOUT - 1);
            x = blank();
            x.done = 1;
            step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, x, 0, 0, 1);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Single per-cycle comparison against the model queue
    always @(negedge clk_i) begin
        exp_t x;
        if (pkt_done_o === 1'b1) last_done_cyc = cyc;
        if (pay_valid_o === 1'b1) last_pv_cyc = cyc;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("pkt_done", 32'(pkt_done_o), 32'(x.done));
            chk("hdr_valid", 32'(hdr_valid_o), 32'(x.hv));
            if (x.hv) begin
                chk("hdr_vc", 32'(hdr_vc_o), 32'(x.vc));
                chk("hdr_dt", 32'(hdr_dt_o), 32'(x.dt));
                chk("hdr_wc", 32'(hdr_wc_o), 32'(x.wc));
            end
            chk("pay_valid", 32'(pay_valid_o), 32'(x.pv));
            if (x.pv) chk("pay_data", pay_data_o, x.pd);
            chk("pay_keep", 32'(pay_keep_o), 32'(x.keep));
            chk("pay_last", 32'(pay_last_o), 32'(x.last));
            chk("ecc_corr_cnt", 32'(ecc_corr_cnt_o), 32'(x.corr));
            chk("ecc_fail_cnt", 32'(ecc_fail_cnt_o), 32'(x.fail));
            chk("trunc_cnt", 32'(trunc_cnt_o), 32'(x.trunc));
        end
    end

    initial begin
        exp_t x;
        logic [5:0] dt;
        logic [15:0] wc;
        int nw;

        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b1, blank(), 0, 0, 0);
        chk("reset_done", 32'(pkt_done_o), 32'h0);
        chk("reset_corr", 32'(ecc_corr_cnt_o), 32'h0);
        idle(2);

        // Short packet
        send_pkt(2'd0, 6'h00, 16'h1234, 1'b0, 1'b0, 0, 0);
        chk("short_wc_lit", 32'(hdr_wc_o), 32'h1234);
        chk("short_done_lit", 32'(pkt_done_o), 32'h1);
        idle(2);

        // WC=6: second word carries 2 payload bytes and ends the packet
        send_pkt(2'd1, 6'h2A, 16'd6, 1'b0, 1'b0, 2, 0);
        chk("wc6_keep_lit", 32'(pay_keep_o), 32'h3);
        chk("wc6_last_lit", 32'(pay_last_o), 32'h1);
        chk("wc6_done_lit", 32'(pkt_done_o), 32'h1);
        idle(2);

        // WC=4: CRC-only second word
        send_pkt(2'd2, 6'h2B, 16'd4, 1'b0, 1'b0, 2, 0);
        chk("wc4_pv_lit", 32'(pay_valid_o), 32'h0);
        chk("wc4_done_lit", 32'(pkt_done_o), 32'h1);
        idle(2);

        // Uncorrectable header dropped
        send_pkt(2'd0, 6'h2A, 16'd12, 1'b1, 1'b0, 3, 0);
        chk("drop_done_lit", 32'(pkt_done_o), 32'h1);
        chk("drop_fail_lit", 32'(ecc_fail_cnt_o), 32'h1);
        idle(2);

        // Truncated WC=100 packet
        send_pkt(2'd3, 6'h2C, 16'd100, 1'b0, 1'b0, 5, 0);
        @(negedge clk_i); #1;
        chk("trunc_gap_lit", 32'(last_done_cyc - last_pv_cyc), 32'd16);
        chk("trunc_cnt_lit", 32'(trunc_cnt_o), 32'h1);
        idle(2);
        send_pkt(2'd0, 6'h05, 16'hBEEF, 1'b0, 1'b0, 0, 0);
        chk("after_trunc_hv_lit", 32'(hdr_valid_o), 32'h1);
        idle(2);

        // Corrected-header saturation, then clear racing an increment
        for (int i = 0; i < 17; i++) begin
            send_pkt(2'd1, 6'h01, 16'(i), 1'b1, 1'b1, 0, 0);
            idle(2);
        end
        chk("corr_sat_lit", 32'(ecc_corr_cnt_o), 32'hF);
        force_clr = 1'b1;
        send_pkt(2'd1, 6'h01, 16'h0001, 1'b1, 1'b1, 0, 0);
        force_clr = 1'b0;
        chk("corr_clr_lit", 32'(ecc_corr_cnt_o), 32'h0);
        idle(2);

        // Reset in the middle of a long packet
        x = blank(); x.hv = 1; x.vc = 2'd1; x.dt = 6'h2B; x.wc = 16'd100;
        step(1'b1, {8'h00, 16'd100, 2'd1, 6'h2B}, 1'b0, 1'b0, 1'b0, x, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            x = blank(); x.pv = 1; x.keep = 4'hF; x.pd = 32'hA5A5_0000 + 32'(i);
            step(1'b1, x.pd, 1'b0, 1'b0, 1'b0, x, 0, 0, 0);
        end
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, blank(), 0, 0, 0);
        idle(2);
        send_pkt(2'd2, 6'h0A, 16'h00FF, 1'b0, 1'b0, 0, 0);
        chk("post_rst_hv_lit", 32'(hdr_valid_o), 32'h1);
        idle(2);

        // Randomized traffic
        rand_clr = 1'b1;
        for (int p = 0; p < 300; p++) begin
            if ($urandom_range(0, 2) == 0) begin
                dt = 6'($urandom_range(0, 15));
                wc = 16'($urandom);
            end else begin
                dt = 6'($urandom_range(16, 63));
                wc = 16'($urandom_range(0, 40));
            end
            nw = ($urandom_range(0, 5) == 0) ? $urandom_range(0, (int'(wc) + 5) / 4 - 1)
                                             : 1000;
            send_pkt(2'($urandom), dt, wc,
                     ($urandom_range(0, 5) == 0), 1'($urandom), nw,
                     ($urandom_range(0, 1) == 0) ? TIMEOUT - 1 : 0);
            idle($urandom_range(2, 5));
        end
        rand_clr = 1'b0;

        repeat (3) @(negedge clk_i);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
